// File: rtl/pwm_deadtime.sv
`default_nettype none
// ============================================================================
// Module   : pwm_deadtime
// Brief    : Complementary high/low gate driver with break-before-make dead
//            time, short-pulse swallowing and an optional latched fault
//            path compiled in with PWM_DT_FAULT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_deadtime #(
  parameter int DT_W   = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  input  logic              enable,
  input  logic [DT_W-1:0]   dt_cycles,
  input  logic              fault_in,
  input  logic              fault_clr,
  output logic              gate_hi,
  output logic              gate_lo,
  output logic              fault_latched,
  output logic [DROP_W-1:0] drop_cnt
);

`ifdef PWM_DT_FAULT_EN
  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_DT_TO_HI = 3'd1,
    S_HI       = 3'd2,
    S_DT_TO_LO = 3'd3,
    S_LO       = 3'd4,
    S_FAULT    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_DT_TO_HI = 3'd1,
    S_HI       = 3'd2,
    S_DT_TO_LO = 3'd3,
    S_LO       = 3'd4
  } state_t;
`endif

  localparam logic [DROP_W-1:0] C_DROP_MAX = '1;

  state_t            state_q, state_d;
  logic [DT_W-1:0]   cnt_q, cnt_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              pwm_q, pwm_d;
  logic              gate_hi_q, gate_hi_d;
  logic              gate_lo_q, gate_lo_d;
  logic              drop_inc;

`ifdef PWM_DT_FAULT_EN
  logic fault_meta_q, fault_meta_d;
  logic fault_s_q, fault_s_d;
  logic fault_latched_q, fault_latched_d;

  // Two-flop synchroniser for the asynchronous fault input
  always_comb begin
    fault_meta_d = fault_in;
    fault_s_d    = fault_meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_meta_q    <= 1'b0;
      fault_s_q       <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      fault_meta_q    <= fault_meta_d;
      fault_s_q       <= fault_s_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  always_comb begin
    fault_latched_d = (state_d == S_FAULT);
  end

  assign fault_latched = fault_latched_q;
`else
  logic unused_fault;
  assign unused_fault  = fault_in ^ fault_clr;
  assign fault_latched = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    drop_inc = 1'b0;
    pwm_d    = pwm_in;

`ifdef PWM_DT_FAULT_EN
    if (fault_s_q) begin
      state_d = S_FAULT;
      cnt_d   = '0;
    end else if (state_q == S_FAULT) begin
      cnt_d = '0;
      if (fault_clr) state_d = S_OFF;
    end else
`endif
    if (!enable) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = pwm_q ? S_DT_TO_HI : S_DT_TO_LO;
          cnt_d   = dt_cycles;
        end
        S_HI: begin
          if (!pwm_q) begin
            state_d = S_DT_TO_LO;
            cnt_d   = dt_cycles;
          end
        end
        S_LO: begin
          if (pwm_q) begin
            state_d = S_DT_TO_HI;
            cnt_d   = dt_cycles;
          end
        end
        // A revert during dead time beats expiry: the pulse is swallowed
        S_DT_TO_HI: begin
          if (!pwm_q) begin
            state_d  = S_DT_TO_LO;
            cnt_d    = dt_cycles;
            drop_inc = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = S_HI;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        S_DT_TO_LO: begin
          if (pwm_q) begin
            state_d  = S_DT_TO_HI;
            cnt_d    = dt_cycles;
            drop_inc = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = S_LO;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    if (drop_inc && (drop_q != C_DROP_MAX)) drop_d = drop_q + DROP_W'(1);

    // Gates decode the next state so they switch on the same edge as the FSM
    gate_hi_d = (state_d == S_HI);
    gate_lo_d = (state_d == S_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      drop_q    <= '0;
      pwm_q     <= 1'b0;
      gate_hi_q <= 1'b0;
      gate_lo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      pwm_q     <= pwm_d;
      gate_hi_q <= gate_hi_d;
      gate_lo_q <= gate_lo_d;
    end
  end

  assign gate_hi  = gate_hi_q;
  assign gate_lo  = gate_lo_q;
  assign drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_deadtime.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_deadtime
// Brief    : Scoreboard bench for pwm_deadtime; stimulus queues per-cycle
//            expected gate/fault/drop values, a negedge monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_deadtime;
  localparam int DT_W   = 4;
  localparam int DROP_W = 8;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              pwm_in    = 1'b0;
  logic              enable    = 1'b0;
  logic              fault_in  = 1'b0;
  logic              fault_clr = 1'b0;
  logic [DT_W-1:0]   dt_cycles = '0;
  logic              gate_hi;
  logic              gate_lo;
  logic              fault_latched;
  logic [DROP_W-1:0] drop_cnt;

  typedef struct {
    int                cyc;
    logic              hi;
    logic              lo;
    logic              flt;
    logic [DROP_W-1:0] drop;
    string             name;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              m;
  int                cyc      = 0;
  int                checks   = 0;
  int                errors   = 0;
  logic [DROP_W-1:0] exp_drop = '0;
  bit                drain    = 1'b0;

  pwm_deadtime #(
    .DT_W   (DT_W),
    .DROP_W (DROP_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm_in        (pwm_in),
    .enable        (enable),
    .dt_cycles     (dt_cycles),
    .fault_in      (fault_in),
    .fault_clr     (fault_clr),
    .gate_hi       (gate_hi),
    .gate_lo       (gate_lo),
    .fault_latched (fault_latched),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Queue the expected outputs after edges from..to (inclusive)
  task automatic push_range(input int from, input int to, input logic hi,
                            input logic lo, input logic flt, input string nm);
    exp_t e;
    for (int c = from; c <= to; c++) begin
      e.cyc  = c;
      e.hi   = hi;
      e.lo   = lo;
      e.flt  = flt;
      e.drop = exp_drop;
      e.name = nm;
      exp_q.push_back(e);
    end
  endtask

  // Return just after the edge preceding edge e, so inputs set now are seen at edge e
  task automatic at_edge(input int e);
    while (cyc + 1 < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // pwm_in high for h cycles starting at edge k, then low; LO held for tail cycles
  task automatic pwm_pulse(input int k, input int d, input int h, input int tail,
                           input string nm);
    at_edge(k);
    pwm_in = 1'b1;
    push_range(k + 1, k + 1 + d, 1'b0, 1'b0, 1'b0, {nm, "_dt_rise"});
    push_range(k + 2 + d, k + h, 1'b1, 1'b0, 1'b0, {nm, "_hi"});
    push_range(k + h + 1, k + h + 1 + d, 1'b0, 1'b0, 1'b0, {nm, "_dt_fall"});
    push_range(k + h + 2 + d, k + h + 1 + d + tail, 1'b0, 1'b1, 1'b0, {nm, "_lo"});
    at_edge(k + h);
    pwm_in = 1'b0;
  endtask

  always @(negedge clk) begin
    checks++;
    if (gate_hi && gate_lo) begin
      errors++;
      $display("FAIL overlap cyc=%0d: gate_hi=%b gate_lo=%b, required never both 1",
               cyc, gate_hi, gate_lo);
    end
    while (exp_q.size() > 0 && (exp_q[0].cyc <= cyc || drain)) begin
      m = exp_q.pop_front();
      checks++;
      if (m.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expected observation at cycle %0d, monitor at cycle %0d",
                 m.name, m.cyc, cyc);
      end else if ({gate_hi, gate_lo, fault_latched, drop_cnt} !==
                   {m.hi, m.lo, m.flt, m.drop}) begin
        errors++;
        $display("FAIL %s cyc=%0d: got hi=%b lo=%b flt=%b drop=%0d, required hi=%b lo=%b flt=%b drop=%0d",
                 m.name, cyc, gate_hi, gate_lo, fault_latched, drop_cnt,
                 m.hi, m.lo, m.flt, m.drop);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, k, k5, k6, k7, e;

    push_range(1, 2, 1'b0, 1'b0, 1'b0, "reset");
    push_range(3, 4, 1'b0, 1'b0, 1'b0, "off_disabled");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic dead time, dt=3
    a = 5;
    at_edge(a);
    enable    = 1'b1;
    dt_cycles = 4'd3;
    push_range(a, a + 3, 1'b0, 1'b0, 1'b0, "startup_dt");
    push_range(a + 4, a + 8, 1'b0, 1'b1, 1'b0, "startup_lo");
    k = a + 8;
    pwm_pulse(k, 3, 8, 4, "dt3_p1");
    pwm_pulse(k + 16, 3, 8, 4, "dt3_p2");
    // Mid-dead-time change must not disturb the running count
    at_edge(k + 27);
    dt_cycles = 4'd0;

    // Zero dead time
    pwm_pulse(k + 32, 0, 8, 4, "dt0_p1");
    pwm_pulse(k + 45, 0, 8, 4, "dt0_p2");

    // Short pulse swallowed, dt=5
    k5 = k + 58;
    at_edge(k5);
    pwm_in    = 1'b1;
    dt_cycles = 4'd5;
    push_range(k5 + 1, k5 + 2, 1'b0, 1'b0, 1'b0, "short_dt_hi");
    at_edge(k5 + 2);
    pwm_in   = 1'b0;
    exp_drop = 8'd1;
    push_range(k5 + 3, k5 + 8, 1'b0, 1'b0, 1'b0, "short_dt_lo");
    push_range(k5 + 9, k5 + 12, 1'b0, 1'b1, 1'b0, "short_lo");

    // Enable drop during DT_TO_HI, restart, then async reset while in HI
    k6 = k5 + 12;
    at_edge(k6);
    pwm_in = 1'b1;
    push_range(k6 + 1, k6 + 2, 1'b0, 1'b0, 1'b0, "en_dt");
    at_edge(k6 + 3);
    enable = 1'b0;
    push_range(k6 + 3, k6 + 6, 1'b0, 1'b0, 1'b0, "en_off");
    at_edge(k6 + 7);
    enable    = 1'b1;
    dt_cycles = 4'd2;
    push_range(k6 + 7, k6 + 9, 1'b0, 1'b0, 1'b0, "en_restart_dt");
    push_range(k6 + 10, k6 + 11, 1'b1, 1'b0, 1'b0, "en_restart_hi");
    at_edge(k6 + 13);
    rst_n    = 1'b0;
    exp_drop = 8'd0;
    push_range(k6 + 12, k6 + 14, 1'b0, 1'b0, 1'b0, "async_reset");
    at_edge(k6 + 15);
    rst_n     = 1'b1;
    pwm_in    = 1'b0;
    dt_cycles = 4'd1;
    push_range(k6 + 15, k6 + 16, 1'b0, 1'b0, 1'b0, "post_reset_dt");
    push_range(k6 + 17, k6 + 19, 1'b0, 1'b1, 1'b0, "post_reset_lo");

    // Saturation: pwm toggles every cycle inside a long dead time
    k7 = k6 + 19;
    exp_drop = 8'd100;
    push_range(k7 + 101, k7 + 101, 1'b0, 1'b0, 1'b0, "sat_100");
    exp_drop = 8'd254;
    push_range(k7 + 255, k7 + 255, 1'b0, 1'b0, 1'b0, "sat_254");
    exp_drop = 8'd255;
    push_range(k7 + 256, k7 + 256, 1'b0, 1'b0, 1'b0, "sat_255");
    push_range(k7 + 300, k7 + 300, 1'b0, 1'b0, 1'b0, "sat_hold");
    push_range(k7 + 315, k7 + 315, 1'b0, 1'b0, 1'b0, "sat_last_dt");
    push_range(k7 + 316, k7 + 318, 1'b0, 1'b1, 1'b0, "sat_lo");
    for (int i = 0; i < 300; i++) begin
      at_edge(k7 + i);
      if (i == 0) dt_cycles = 4'd15;
      pwm_in = (i % 2 == 0);
    end

    e = k7 + 318;
    at_edge(e);
    pwm_in    = 1'b1;
    dt_cycles = 4'd2;
    push_range(e + 1, e + 3, 1'b0, 1'b0, 1'b0, "pre_fault_dt");
`ifdef PWM_DT_FAULT_EN
    push_range(e + 4, e + 7, 1'b1, 1'b0, 1'b0, "pre_fault_hi");
    push_range(e + 8, e + 15, 1'b0, 1'b0, 1'b1, "fault_latched");
    push_range(e + 16, e + 19, 1'b0, 1'b0, 1'b0, "fault_clear_dt");
    push_range(e + 20, e + 22, 1'b1, 1'b0, 1'b0, "fault_clear_hi");
    at_edge(e + 6);
    fault_in = 1'b1;
    at_edge(e + 10);
    fault_clr = 1'b1;
    at_edge(e + 11);
    fault_clr = 1'b0;
    fault_in  = 1'b0;
    at_edge(e + 16);
    fault_clr = 1'b1;
    at_edge(e + 17);
    fault_clr = 1'b0;
`else
    push_range(e + 4, e + 15, 1'b1, 1'b0, 1'b0, "fault_ignored_hi");
    at_edge(e + 6);
    fault_in  = 1'b1;
    fault_clr = 1'b1;
    at_edge(e + 10);
    fault_in  = 1'b0;
    fault_clr = 1'b0;
`endif

    at_edge(e + 25);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    drain = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
